scad_seq: RTL and testbench

SCAD_SEQ -- requirements
Module: scad_seq

---
 rtl/scad_seq_pkg.sv | 20 ++
 rtl/scad_stepcnt.sv | 33 +++
 rtl/scad_seq.sv | 129 ++++++++++++
 tb/tb_scad_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scad_seq_pkg.sv
// Shared CROM constants for the SCAD datapath and its sequencer.
//   scad_fun_t  : SCAD ALU function select codes
//   scada_sel_t : SCADA mux select codes
//   CNT_W       : width of the step counter / small-number field
package scad_seq_pkg;

  typedef enum logic [2:0] {
    SCAD_APLUSA  = 3'b000,
    SCAD_AMINUS1 = 3'b110,
    SCAD_A       = 3'b111
  } scad_fun_t;

  typedef enum logic [2:0] {
    SCADA_SC   = 3'b000,
    SCADA_SNUM = 3'b001
  } scada_sel_t;

  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/scad_stepcnt.sv
// Loadable, decrementing step counter for the SCAD sequencer.
//   clk, rst   : clock, asynchronous active-low reset
//   load, din  : load din into the counter (priority over dec)
//   dec        : decrement by one (10-bit wrap); dec=0 holds the value
//   cnt        : counter value, bit 0 is the sign (MSB)
//   sign, zero : cnt negative / cnt equal to zero
module scad_stepcnt
  import scad_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [0:CNT_W-1] din,
  output logic [0:CNT_W-1] cnt,
  output logic             sign,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign sign = cnt[0];
  assign zero = (cnt == '0);

endmodule

// File: rtl/scad_seq.sv
// SCAD step sequencer: loads a signed step count into SC, then runs
// count+1 decrement iterations through the SCAD ALU and pulses done.
//   clk, rst     : clock, asynchronous active-low reset
//   clken        : clock enable qualifying every state update
//   start, count : request a sequence with initial step count (bit 0 = sign)
//   hold, abort  : stall the STEP state / abandon the sequence without done
//   scadFun      : SCAD ALU function select
//   scadAsel     : SCADA mux select
//   snum         : small-number value (always the internal counter)
//   loadSC       : SC register load strobe
//   step, busy   : iteration strobe / sequence in progress
//   done         : one-cycle completion strobe
module scad_seq
  import scad_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             start,
  input  logic [0:CNT_W-1] count,
  input  logic             hold,
  input  logic             abort,
  output logic [0:2]       scadFun,
  output logic [0:2]       scadAsel,
  output logic [0:CNT_W-1] snum,
  output logic             loadSC,
  output logic             step,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             done_q;
  logic             cnt_load;
  logic             cnt_dec;
  logic [0:CNT_W-1] cnt;
  logic             cnt_sign;
  logic             cnt_zero;
  logic             step_act;

  scad_stepcnt u_stepcnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .din  (count),
    .cnt  (cnt),
    .sign (cnt_sign),
    .zero (cnt_zero)
  );

  // done is registered so it holds across clken=0 cycles and clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (clken) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_load = 1'b1;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort)         state_d = S_IDLE;
          else if (cnt_sign) state_d = S_DONE;
          else               state_d = S_STEP;
        end
        S_STEP: begin
          if (abort) begin
            state_d = S_IDLE;
          end else if (!hold) begin
            cnt_dec = 1'b1;
            // Decrementing from zero wraps to all-ones: the last iteration.
            if (cnt_zero) state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    scadFun  = SCAD_A;
    scadAsel = SCADA_SC;
    loadSC   = 1'b0;
    step_act = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        scadAsel = SCADA_SNUM;
        busy     = 1'b1;
        loadSC   = clken & ~abort;
      end
      S_STEP: begin
        scadFun  = SCAD_AMINUS1;
        busy     = 1'b1;
        step_act = clken & ~hold & ~abort;
        loadSC   = step_act;
      end
      default: ;
    endcase
  end

  assign step = step_act;
  assign snum = cnt;
  assign done = done_q;

endmodule

// File: tb/tb_scad_seq.sv
module tb_scad_seq;

  logic       clk;
  logic       rst;
  logic       clken;
  logic       start;
  logic [0:9] count;
  logic       hold;
  logic       abort;
  logic [0:2] scadFun;
  logic [0:2] scadAsel;
  logic [0:9] snum;
  logic       loadSC;
  logic       step;
  logic       busy;
  logic       done;

  scad_seq dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .start    (start),
    .count    (count),
    .hold     (hold),
    .abort    (abort),
    .scadFun  (scadFun),
    .scadAsel (scadAsel),
    .snum     (snum),
    .loadSC   (loadSC),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_STEP = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [9:0] val;
  } tok_t;

  tok_t sb[$];
  int   n_chk;
  int   n_fail;
  int   busy_cyc;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    busy_cyc = 0;
  end

  task automatic push(input logic [1:0] kind, input logic [9:0] val);
    tok_t t;
    t.kind = kind;
    t.val  = val;
    sb.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Wait (bounded) for all expected events to be seen and the sequence to end,
  // then give the DUT two enabled edges to return to IDLE.
  task automatic drain(input string nm);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    n_chk++;
    if (sb.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending events busy=%b required 0 pending busy=0",
               nm, sb.size(), busy);
      sb.delete();
    end
    clken = 1'b1;
    tick();
    tick();
  endtask

  // Monitor: samples on the falling edge, so clken reflects the next active edge.
  always @(negedge clk) begin
    tok_t obs;
    tok_t exp;
    if (rst) begin
      if (!clken) begin
        n_chk++;
        if (step || loadSC) begin
          n_fail++;
          $display("FAIL clken_gate: got step=%b loadSC=%b required 0 0", step, loadSC);
        end
      end else begin
        if (busy) busy_cyc++;
        if (loadSC || step || done) begin
          obs.val = snum;
          if (done) begin
            obs.kind = K_DONE;
            n_chk++;
            if (busy || loadSC || step || scadFun !== 3'b111 || scadAsel !== 3'b000) begin
              n_fail++;
              $display("FAIL done_outputs: got busy=%b loadSC=%b step=%b fun=%b asel=%b required 0 0 0 111 000",
                       busy, loadSC, step, scadFun, scadAsel);
            end
          end else if (step) begin
            obs.kind = K_STEP;
            n_chk++;
            if (!loadSC || !busy || scadFun !== 3'b110 || scadAsel !== 3'b000) begin
              n_fail++;
              $display("FAIL step_outputs: got loadSC=%b busy=%b fun=%b asel=%b required 1 1 110 000",
                       loadSC, busy, scadFun, scadAsel);
            end
          end else begin
            obs.kind = K_LOAD;
            n_chk++;
            if (!busy || scadFun !== 3'b111 || scadAsel !== 3'b001) begin
              n_fail++;
              $display("FAIL load_outputs: got busy=%b fun=%b asel=%b required 1 111 001",
                       busy, scadFun, scadAsel);
            end
          end
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d snum=%h required no event", obs.kind, obs.val);
          end else begin
            exp = sb.pop_front();
            if (obs !== exp) begin
              n_fail++;
              $display("FAIL event: got kind=%0d snum=%h required kind=%0d snum=%h",
                       obs.kind, obs.val, exp.kind, exp.val);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required end within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    clken = 1'b1;
    start = 1'b0;
    count = '0;
    hold  = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    chk("rst_busy",  10'(busy), 10'd0);
    chk("rst_done",  10'(done), 10'd0);
    chk("rst_snum",  snum, 10'd0);
    chk("rst_fun",   10'(scadFun), 10'd7);
    chk("rst_asel",  10'(scadAsel), 10'd0);
    chk("rst_strb",  10'({loadSC, step}), 10'd0);
    rst = 1'b1;
    tick();

    // count=3: LOAD, 4 steps, done; a start during STEP is ignored.
    busy_cyc = 0;
    push(K_LOAD, 10'd3);
    for (int v = 3; v >= 0; v--) push(K_STEP, 10'(v));
    push(K_DONE, 10'h3FF);
    count = 10'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; count = 10'd99;
    tick();
    start = 1'b0; count = '0;
    drain("t1");
    chk("t1_busy_cycles", 10'(busy_cyc), 10'd5);

    // count=1777 octal: LOAD then DONE, no steps; start in DONE ignored.
    push(K_LOAD, 10'h3FF);
    push(K_DONE, 10'h3FF);
    count = 10'o1777; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; count = 10'd5;
    tick();
    start = 1'b0;
    tick();
    chk("t2_idle_after_done", 10'(busy), 10'd0);
    drain("t2");

    // count=2, hold during 2nd step cycle.
    push(K_LOAD, 10'd2);
    push(K_STEP, 10'd2);
    push(K_STEP, 10'd1);
    push(K_STEP, 10'd0);
    push(K_DONE, 10'h3FF);
    count = 10'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    hold = 1'b1;
    #1;
    chk("t3_hold_step", 10'(step), 10'd0);
    chk("t3_hold_busy", 10'(busy), 10'd1);
    chk("t3_hold_snum", snum, 10'd1);
    tick();
    hold = 1'b0;
    drain("t3");

    // count=10, abort on 3rd step cycle.
    push(K_LOAD, 10'd10);
    push(K_STEP, 10'd10);
    push(K_STEP, 10'd9);
    count = 10'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_busy", 10'(busy), 10'd0);
    chk("t4_abort_cnt", snum, 10'd8);
    drain("t4");

    // count=5 with clken toggling every cycle.
    push(K_LOAD, 10'd5);
    for (int v = 5; v >= 0; v--) push(K_STEP, 10'(v));
    push(K_DONE, 10'h3FF);
    count = 10'd5; start = 1'b1; clken = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && (sb.size() != 0 || busy); i++) begin
      clken = ~clken;
      tick();
    end
    drain("t5");

    // count=7, reset mid-STEP, then a fresh count=0 sequence.
    push(K_LOAD, 10'd7);
    push(K_STEP, 10'd7);
    count = 10'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", 10'(busy), 10'd0);
    chk("t6_rst_done", 10'(done), 10'd0);
    chk("t6_rst_snum", snum, 10'd0);
    chk("t6_rst_strb", 10'({loadSC, step}), 10'd0);
    chk("t6_rst_fun",  10'(scadFun), 10'd7);
    tick();
    rst = 1'b1;
    chk("t6_events_seen", 10'(sb.size()), 10'd0);
    tick();
    push(K_LOAD, 10'd0);
    push(K_STEP, 10'd0);
    push(K_DONE, 10'h3FF);
    count = 10'd0; start = 1'b1;
    tick();
    start = 1'b0;
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
